// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel output path: Bayer matrix, output byte
// bit positions, rounding threshold and the per-channel quantiser.
package vga_pkg;

  // Index is {row, col}; entry 0 is row 0 col 0.
  localparam logic [15:0][3:0] BayerMatrix = {
    4'd5,  4'd13, 4'd7,  4'd15,
    4'd9,  4'd1,  4'd11, 4'd3,
    4'd6,  4'd14, 4'd4,  4'd12,
    4'd10, 4'd2,  4'd8,  4'd0
  };

  localparam logic [3:0] RoundThreshold = 4'd8;

  localparam int unsigned VgaBitHsync = 7;
  localparam int unsigned VgaBitB0    = 6;
  localparam int unsigned VgaBitG0    = 5;
  localparam int unsigned VgaBitR0    = 4;
  localparam int unsigned VgaBitVsync = 3;
  localparam int unsigned VgaBitB1    = 2;
  localparam int unsigned VgaBitG1    = 1;
  localparam int unsigned VgaBitR1    = 0;

  localparam int unsigned ChR = 0;
  localparam int unsigned ChG = 1;
  localparam int unsigned ChB = 2;

  // 3*c + c[3:2] spreads 0..15 over 0..48 so c=15 lands on 3 for any threshold.
  function automatic logic [1:0] quantise(input logic [3:0] c, input logic [3:0] t);
    logic [5:0] sum;
    sum = 6'(c) * 6'd3 + {4'b0000, c[3:2]} + {2'b00, t};
    return sum[5:4];
  endfunction

endpackage

// File: rtl/bayer4x4_rom.sv
// Combinational 4x4 ordered-dither threshold lookup.
module bayer4x4_rom
  import vga_pkg::*;
(
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] t
);

  assign t = BayerMatrix[{row, col}];

endmodule

// File: rtl/vga_dither_stage.sv
// Pixel output stage: 4-bit colour to 2-bit VGA DAC with 4x4 ordered dither,
// optional per-frame pattern rotation, and syncs kept aligned with colour.
module vga_dither_stage
  import vga_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned H_BITS      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [H_BITS-1:0] hpos,
  input  logic [H_BITS-1:0] vpos,
  input  logic              display_on,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic [3:0]        r_in,
  input  logic [3:0]        g_in,
  input  logic [3:0]        b_in,
  input  logic              dither_en,
  input  logic              temporal_en,
  output logic [1:0]        r_o,
  output logic [1:0]        g_o,
  output logic [1:0]        b_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [7:0]        vga_byte
);

  if (PIPE_STAGES != 2) begin : gen_pipe_check
    $error("vga_dither_stage: only PIPE_STAGES == 2 is supported");
  end

  logic            frame_start;
  logic [1:0]      fc_q;
  logic [1:0]      f_eff;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [3:0]      bayer_t;
  logic [3:0]      thresh_d;

  logic [2:0][3:0] colour_s1_q;
  logic [3:0]      thresh_s1_q;
  logic            de_s1_q;
  logic            hs_s1_q;
  logic            vs_s1_q;

  logic [2:0][1:0] quant_d;
  logic [2:0][1:0] quant_q;
  logic            hs_q;
  logic            vs_q;

  // The frame counter bumps on the (0,0) pixel itself, so the whole frame
  // including its first pixel sees one pattern phase.
  always_comb begin
    frame_start = (hpos == '0) && (vpos == '0);
    f_eff       = fc_q + {1'b0, frame_start};
    row_idx     = vpos[1:0] ^ (temporal_en ? f_eff : 2'b00);
    col_idx     = hpos[1:0] ^ (temporal_en ? {f_eff[0], f_eff[1]} : 2'b00);
    thresh_d    = dither_en ? bayer_t : RoundThreshold;
  end

  bayer4x4_rom u_bayer (
    .row (row_idx),
    .col (col_idx),
    .t   (bayer_t)
  );

  for (genvar ch = 0; ch < 3; ch++) begin : gen_quant
    assign quant_d[ch] = de_s1_q ? quantise(colour_s1_q[ch], thresh_s1_q) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q        <= '0;
      colour_s1_q <= '0;
      thresh_s1_q <= '0;
      de_s1_q     <= 1'b0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      quant_q     <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      fc_q        <= f_eff;
      colour_s1_q <= {b_in, g_in, r_in};
      thresh_s1_q <= thresh_d;
      de_s1_q     <= display_on;
      hs_s1_q     <= hsync_i;
      vs_s1_q     <= vsync_i;
      quant_q     <= quant_d;
      hs_q        <= hs_s1_q;
      vs_q        <= vs_s1_q;
    end
  end

  assign r_o     = quant_q[ChR];
  assign g_o     = quant_q[ChG];
  assign b_o     = quant_q[ChB];
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

  always_comb begin
    vga_byte              = '0;
    vga_byte[VgaBitHsync] = hs_q;
    vga_byte[VgaBitB0]    = quant_q[ChB][0];
    vga_byte[VgaBitG0]    = quant_q[ChG][0];
    vga_byte[VgaBitR0]    = quant_q[ChR][0];
    vga_byte[VgaBitVsync] = vs_q;
    vga_byte[VgaBitB1]    = quant_q[ChB][1];
    vga_byte[VgaBitG1]    = quant_q[ChG][1];
    vga_byte[VgaBitR1]    = quant_q[ChR][1];
  end

endmodule

// File: tb/tb_vga_dither_stage.sv
// Directed self-checking bench for vga_dither_stage.
module tb_vga_dither_stage;

  logic       clk;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_i;
  logic       vsync_i;
  logic [3:0] r_in;
  logic [3:0] g_in;
  logic [3:0] b_in;
  logic       dither_en;
  logic       temporal_en;
  logic [1:0] r_o;
  logic [1:0] g_o;
  logic [1:0] b_o;
  logic       hsync_o;
  logic       vsync_o;
  logic [7:0] vga_byte;

  int asserts = 0;
  int fails   = 0;

  vga_dither_stage #(
    .PIPE_STAGES (2),
    .H_BITS      (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .hsync_i     (hsync_i),
    .vsync_i     (vsync_i),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .dither_en   (dither_en),
    .temporal_en (temporal_en),
    .r_o         (r_o),
    .g_o         (g_o),
    .b_o         (b_o),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .vga_byte    (vga_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pos();
    hpos = 10'd5;
    vpos = 10'd5;
  endtask

  // One (0,0) pixel followed by a non-origin pixel: exactly one frame start.
  task automatic frame_start();
    hpos = 10'd0;
    vpos = 10'd0;
    step();
    idle_pos();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; hsync_i = 1'b1; vsync_i = 1'b0; display_on = 1'b1;
    r_in = 4'd15; g_in = 4'd0; b_in = 4'd0; dither_en = 1'b0; temporal_en = 1'b0;
    idle_pos();
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++;
      if ({r_o, g_o, b_o, hsync_o, vsync_o, vga_byte} !== 16'h0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: r=%0d g=%0d b=%0d hs=%0b vs=%0b byte=%h, want all 0",
                 i, r_o, g_o, b_o, hsync_o, vsync_o, vga_byte);
      end
    end
    reset = 1'b0;
    step();
    asserts++;
    if (hsync_o !== 1'b0 || r_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_release_e1: hs=%0b r=%0d, want hs=0 r=0", hsync_o, r_o);
    end
    step();
    asserts++;
    if (hsync_o !== 1'b1 || r_o !== 2'd3 || vga_byte !== 8'b1001_0001) begin
      fails++;
      $display("FAIL reset_release_e2: hs=%0b r=%0d byte=%b, want hs=1 r=3 byte=10010001",
               hsync_o, r_o, vga_byte);
    end
  endtask

  task automatic test_rounding();
    hsync_i = 1'b0; vsync_i = 1'b0; display_on = 1'b1; dither_en = 1'b0;
    r_in = 4'd15; g_in = 4'd8; b_in = 4'd0;
    step(); step();
    asserts++;
    if (r_o !== 2'd3 || g_o !== 2'd2 || b_o !== 2'd0 || vga_byte !== 8'b0001_0011) begin
      fails++;
      $display("FAIL round_15_8_0: r=%0d g=%0d b=%0d byte=%b, want 3 2 0 byte=00010011",
               r_o, g_o, b_o, vga_byte);
    end
    r_in = 4'd5; g_in = 4'd10; b_in = 4'd1;
    step(); step();
    asserts++;
    if (r_o !== 2'd1 || g_o !== 2'd2 || b_o !== 2'd0) begin
      fails++;
      $display("FAIL round_5_10_1: r=%0d g=%0d b=%0d, want 1 2 0", r_o, g_o, b_o);
    end
  endtask

  task automatic test_spatial();
    logic [1:0] exp_g [16];
    // g=8 gives 2 where Bayer threshold >= 6, else 1.
    exp_g = '{2'd1, 2'd2, 2'd1, 2'd2,
              2'd2, 2'd1, 2'd2, 2'd2,
              2'd1, 2'd2, 2'd1, 2'd2,
              2'd2, 2'd2, 2'd2, 2'd1};
    dither_en = 1'b1; temporal_en = 1'b0; display_on = 1'b1;
    r_in = 4'd0; g_in = 4'd8; b_in = 4'd0;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        hpos = 10'(k % 4);
        vpos = 10'(k / 4);
      end else begin
        idle_pos();
      end
      step();
      if (k >= 1) begin
        asserts++;
        if (g_o !== exp_g[k-1]) begin
          fails++;
          $display("FAIL spatial h%0d v%0d: g=%0d, want %0d", (k-1) % 4, (k-1) / 4,
                   g_o, exp_g[k-1]);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [5:0] hs_pat;
    logic [5:0] vs_pat;
    hs_pat = 6'b101100;
    vs_pat = 6'b011010;
    display_on = 1'b0; r_in = 4'd15; g_in = 4'd15; b_in = 4'd15;
    idle_pos();
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        hsync_i = hs_pat[k];
        vsync_i = vs_pat[k];
      end
      step();
      if (k >= 1) begin
        asserts++;
        if (hsync_o !== hs_pat[k-1] || vsync_o !== vs_pat[k-1] ||
            {r_o, g_o, b_o} !== 6'd0 ||
            vga_byte !== {hs_pat[k-1], 3'b000, vs_pat[k-1], 3'b000}) begin
          fails++;
          $display("FAIL blanking k%0d: hs=%0b vs=%0b rgb=%0d%0d%0d byte=%b, want hs=%0b vs=%0b rgb=0",
                   k-1, hsync_o, vsync_o, r_o, g_o, b_o, vga_byte, hs_pat[k-1], vs_pat[k-1]);
        end
      end
    end
    hsync_i = 1'b0; vsync_i = 1'b0;
  endtask

  task automatic test_temporal();
    logic [1:0] exp_q [4];
    // c=4 at (0,0): f_eff 1,2,3,0 gives thresholds 14,11,5,0.
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd0};
    idle_pos();
    reset = 1'b1;
    step();
    reset = 1'b0;
    display_on = 1'b1; dither_en = 1'b1; temporal_en = 1'b1;
    r_in = 4'd4; g_in = 4'd4; b_in = 4'd4;
    for (int f = 0; f < 4; f++) begin
      frame_start();
      asserts++;
      if (r_o !== exp_q[f] || g_o !== exp_q[f] || b_o !== exp_q[f]) begin
        fails++;
        $display("FAIL temporal f_eff%0d: r=%0d g=%0d b=%0d, want %0d", (f + 1) % 4,
                 r_o, g_o, b_o, exp_q[f]);
      end
    end
    asserts++;
    if (dut.fc_q !== 2'd0) begin
      fails++;
      $display("FAIL fc_wrap: fc=%0d, want 0", dut.fc_q);
    end
  endtask

  task automatic test_reset_mid_frame();
    idle_pos();
    reset = 1'b1;
    step();
    reset = 1'b0;
    display_on = 1'b1; dither_en = 1'b1; temporal_en = 1'b1;
    r_in = 4'd4; g_in = 4'd4; b_in = 4'd4;
    for (int f = 0; f < 3; f++) frame_start();
    asserts++;
    if (dut.fc_q !== 2'd3) begin
      fails++;
      $display("FAIL fc_after_3_frames: fc=%0d, want 3", dut.fc_q);
    end
    hpos = 10'd100; vpos = 10'd200;
    reset = 1'b1;
    step();
    asserts++;
    if (dut.fc_q !== 2'd0 || {r_o, g_o, b_o, hsync_o, vsync_o} !== 8'd0) begin
      fails++;
      $display("FAIL midframe_reset: fc=%0d r=%0d g=%0d b=%0d, want all 0",
               dut.fc_q, r_o, g_o, b_o);
    end
    reset = 1'b0;
    hpos = 10'd0; vpos = 10'd0;
    step();
    asserts++;
    if (dut.fc_q !== 2'd1 || r_o !== 2'd0) begin
      fails++;
      $display("FAIL restart_fc: fc=%0d r=%0d, want fc=1 r=0", dut.fc_q, r_o);
    end
    idle_pos();
    step();
    asserts++;
    if (r_o !== 2'd1 || g_o !== 2'd1 || b_o !== 2'd1) begin
      fails++;
      $display("FAIL restart_pixel: r=%0d g=%0d b=%0d, want 1 1 1", r_o, g_o, b_o);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_spatial();
    test_blanking();
    test_temporal();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/vga_dither_stage.md
# vga_dither_stage

Pixel output stage between the scene renderer and the TinyTapeout `uo_out` pins. It accepts 4-bit-per-channel colour plus raw sync/position from the renderer and reduces each channel to the 2-bit VGA DAC format, using 4×4 ordered (Bayer) dithering with an optional per-frame pattern rotation. It delays sync signals to stay aligned with colour and emits the packed output byte.

## Interface
Parameters:
- `PIPE_STAGES`, 2, fixed pipeline depth; only value 2 is supported.
- `H_BITS`, 10, width of `hpos`/`vpos`.

Ports:
- `clk` in 1 — pixel clock.
- `reset` in 1 — synchronous, active-high reset.
- `hpos` in 10 — current pixel column from the sync generator.
- `vpos` in 10 — current pixel row.
- `display_on` in 1 — active-video flag.
- `hsync_i`, `vsync_i` in 1 each — raw syncs, polarity passed through untouched.
- `r_in`, `g_in`, `b_in` in 4 each — renderer colour, 0..15.
- `dither_en` in 1 — 1 selects Bayer threshold; 0 selects fixed rounding.
- `temporal_en` in 1 — 1 rotates the Bayer pattern each frame.
- `r_o`, `g_o`, `b_o` out 2 each — quantised colour.
- `hsync_o`, `vsync_o` out 1 each — delayed syncs.
- `vga_byte` out 8 — `{hsync_o, b_o[0], g_o[0], r_o[0], vsync_o, b_o[1], g_o[1], r_o[1]}`.

## Operation
- Stage 1 registers: colour, `display_on`, syncs, threshold `t` (4 bits).
- Stage 2 registers: quantised colour (forced 0 when the stage-1 `display_on` is 0), syncs.
- Frame counter `fc` (2 bits) always runs, independent of enables. Each cycle:
  - `f_eff = (hpos==0 && vpos==0) ? fc+1 : fc` (mod 4).
  - `fc <= f_eff`.
  - As a result, every pixel of a frame, including (0,0), uses the same value.
- Threshold index:
  - `row = vpos[1:0] ^ (temporal_en ? f_eff : 0)`.
  - `col = hpos[1:0] ^ (temporal_en ? {f_eff[0], f_eff[1]} : 0)`.
- Bayer matrix, row-major:
  - row 0: 0,8,2,10
  - row 1: 12,4,14,6
  - row 2: 3,11,1,9
  - row 3: 15,7,13,5
- `t = dither_en ? bayer[row][col] : 8`.
- Quantisation per channel `c`:
  - `s = 3*c + c[3:2]` (6-bit, range 0..48).
  - `q = (s + t)[5:4]`.
  - The sum is at most 63, so no saturation logic is needed.
  - `c=0` always gives 0; `c=15` always gives 3.
- Syncs and `vga_byte` never depend on `dither_en`/`temporal_en`.

## Timing
- Latency is exactly 2 cycles from inputs to every output: colour, syncs and `vga_byte` stay aligned.
- Throughput is one pixel per clock. There is no handshake and no stall.
- Reset state:
  - All stage registers, all outputs (including `hsync_o`/`vsync_o`) and `fc` are 0.
  - Outputs stay 0 during reset and for the 2 cycles after deassertion. The first live output is the input sampled on the first non-reset edge.
- Reset mid-frame: pipeline is flushed and `fc` returns to 0. No recovery handshake is required.
- `dither_en`/`temporal_en` toggling mid-line takes effect on the next sampled pixel; no glitch filtering.
- `fc` wraps 3→0.

## Structure
- Shared package `vga_pkg` holds:
  - the Bayer matrix constant;
  - `vga_byte` bit-position constants;
  - the fixed rounding threshold (8).
- One sub-module `bayer4x4_rom`: combinational `row`,`col` → `t`; reused by future effects.
- Quantiser is a function or generate block instantiated three times.

## Test plan
- Reset: hold `reset` 3 cycles with `hsync_i=1`, `r_in=15` → all outputs 0. Release → `hsync_o=1`, `r_o=3` exactly 2 cycles after the first non-reset edge.
- Rounding, `dither_en=0`, `display_on=1`, r=15/g=8/b=0 → `r_o=3`, `g_o=2`, `b_o=0`, `vga_byte=8'b0_0_0_1_0_0_1_1` (with syncs 0) after 2 cycles.
- Spatial dither, `dither_en=1`, `temporal_en=0`, g=8 over the 4×4 block hpos/vpos 0..3 → `g_o=2` at exactly the 10 positions with t≥6 and `g_o=1` elsewhere.
- Blanking: `display_on=0`, all colours 15, syncs toggling → colour outputs 0; syncs reproduced with 2-cycle delay.
- Temporal: `temporal_en=1`, `dither_en=1`, c=4, `fc=0`, drive (0,0) → `f_eff=1`, t=14, `q=1`. Same pixel in the previous frame (t=0) → `q=0`.
- Reset mid-frame: after 3 frame starts (`fc=3`), assert `reset` at (100,200), then restart at (0,0) → `fc` reads 1 and pixel (0,0) uses `f_eff=1`.
